// File: rtl/imem_boot_loader.sv
// Serial boot loader sitting in front of the instruction memory.
// Unpacks a framed little-endian program image from a UART byte stream,
// writes it into IMEM one word at a time and releases the core with
// 'start' only once the image checksum has been verified.
module imem_boot_loader #(
   parameter int         IMEM_WORDS     = 1024,
   parameter logic [7:0] MAGIC          = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 1000000,
   parameter bit         SKIP_LOAD      = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        prog_en,
   output logic [31:0] prog_addr,
   output logic [31:0] prog_data,
   output logic        start,
   output logic        busy,
   output logic        load_err
);

   // Word index is one bit wider than the address range so that a full
   // image (CNT == IMEM_WORDS) can count past the last word without wrapping.
   localparam int          WIDX      = $clog2(IMEM_WORDS) + 1;
   localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [31:0] MAX_WORDS = IMEM_WORDS;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_CSUM,
      S_RUN,
      S_ERROR
   } state_t;

   localparam state_t RESET_STATE = SKIP_LOAD ? S_RUN : S_IDLE;

   state_t          state_q, state_d;
   logic [15:0]     cnt_q, cnt_d;
   logic [WIDX-1:0] word_idx_q, word_idx_d;
   logic [1:0]      lane_q, lane_d;
   logic [23:0]     word_q, word_d;
   logic [7:0]      csum_q, csum_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            prog_en_q, prog_en_d;
   logic [31:0]     prog_addr_q, prog_addr_d;
   logic [31:0]     prog_data_q, prog_data_d;
   logic [15:0]     cnt_full;
   logic            last_word;
   logic            in_frame;

   // Frame decoding: next state, byte assembly, checksum and idle timeout.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      word_idx_d  = word_idx_q;
      lane_d      = lane_q;
      word_d      = word_q;
      csum_d      = csum_q;
      tmo_d       = tmo_q;
      prog_en_d   = 1'b0;
      prog_addr_d = prog_addr_q;
      prog_data_d = prog_data_q;
      cnt_full    = {rx_data, cnt_q[7:0]};
      last_word   = (32'(word_idx_q) == (32'(cnt_q) - 32'd1));
      in_frame    = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                    (state_q == S_DATA) || (state_q == S_CSUM);

      case (state_q)
         S_IDLE, S_RUN, S_ERROR: begin
            if (rx_valid && (rx_data == MAGIC)) begin
               state_d    = S_LEN0;
               word_idx_d = '0;
               lane_d     = '0;
               word_d     = '0;
               csum_d     = '0;
               tmo_d      = '0;
            end
         end
         S_LEN0: begin
            if (rx_valid) begin
               cnt_d   = {8'h00, rx_data};
               state_d = S_LEN1;
            end
         end
         S_LEN1: begin
            if (rx_valid) begin
               cnt_d = cnt_full;
               if (cnt_full == 16'd0) begin
                  state_d = S_CSUM;
               end else if (32'(cnt_full) > MAX_WORDS) begin
                  state_d = S_ERROR;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (rx_valid) begin
               csum_d = csum_q ^ rx_data;
               lane_d = lane_q + 2'd1;
               case (lane_q)
                  2'd0: word_d[7:0]   = rx_data;
                  2'd1: word_d[15:8]  = rx_data;
                  2'd2: word_d[23:16] = rx_data;
                  default: begin
                     prog_en_d   = 1'b1;
                     prog_addr_d = 32'(word_idx_q) << 2;
                     prog_data_d = {rx_data, word_q};
                     word_idx_d  = word_idx_q + WIDX'(1);
                     if (last_word) begin
                        state_d = S_CSUM;
                     end
                  end
               endcase
            end
         end
         S_CSUM: begin
            if (rx_valid) begin
               state_d = (rx_data == csum_q) ? S_RUN : S_ERROR;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A byte arriving on the expiry cycle wins: it restarts the count.
      if (in_frame) begin
         if (rx_valid) begin
            tmo_d = '0;
         end else if (tmo_q == TMO_LAST) begin
            state_d = S_ERROR;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end
   end

   // State and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RESET_STATE;
         cnt_q       <= '0;
         word_idx_q  <= '0;
         lane_q      <= '0;
         word_q      <= '0;
         csum_q      <= '0;
         tmo_q       <= '0;
         prog_en_q   <= 1'b0;
         prog_addr_q <= '0;
         prog_data_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         word_idx_q  <= word_idx_d;
         lane_q      <= lane_d;
         word_q      <= word_d;
         csum_q      <= csum_d;
         tmo_q       <= tmo_d;
         prog_en_q   <= prog_en_d;
         prog_addr_q <= prog_addr_d;
         prog_data_q <= prog_data_d;
      end
   end

   // Status outputs follow the registered state directly.
   always_comb begin
      prog_en   = prog_en_q;
      prog_addr = prog_addr_q;
      prog_data = prog_data_q;
      start     = (state_q == S_RUN);
      load_err  = (state_q == S_ERROR);
      busy      = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                  (state_q == S_DATA) || (state_q == S_CSUM);
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for the IMEM boot loader: good/bad frames, oversize count,
// MAGIC as payload, idle timeout edge, reload while running, mid-frame reset
// and the SKIP_LOAD variant.
module tb_imem_boot_loader;

   localparam int TMO = 20;

   logic        clk;
   logic        rst;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        prog_en;
   logic [31:0] prog_addr;
   logic [31:0] prog_data;
   logic        start;
   logic        busy;
   logic        load_err;

   logic        rx_valid2;
   logic [7:0]  rx_data2;
   logic        prog_en2;
   logic [31:0] prog_addr2;
   logic [31:0] prog_data2;
   logic        start2;
   logic        busy2;
   logic        load_err2;

   int checks;
   int errors;
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int base;

   imem_boot_loader #(
      .IMEM_WORDS(1024), .MAGIC(8'hA5), .TIMEOUT_CYCLES(TMO), .SKIP_LOAD(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
      .prog_en(prog_en), .prog_addr(prog_addr), .prog_data(prog_data),
      .start(start), .busy(busy), .load_err(load_err)
   );

   imem_boot_loader #(
      .IMEM_WORDS(1024), .MAGIC(8'hA5), .TIMEOUT_CYCLES(TMO), .SKIP_LOAD(1'b1)
   ) dut_skip (
      .clk(clk), .rst(rst), .rx_valid(rx_valid2), .rx_data(rx_data2),
      .prog_en(prog_en2), .prog_addr(prog_addr2), .prog_data(prog_data2),
      .start(start2), .busy(busy2), .load_err(load_err2)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every IMEM write seen by the main instance.
   always @(negedge clk) begin
      if (prog_en) begin
         wr_addr.push_back(prog_addr);
         wr_data.push_back(prog_data);
      end
   end

   // Hard stop if the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
      rx_valid2 = 1'b0;
      rx_data2  = 8'h00;
      waitCycles(2);

      // Reset state of both variants.
      checkOutput("rst_prog_en", 32'(prog_en), 32'd0);
      checkOutput("rst_addr", prog_addr, 32'd0);
      checkOutput("rst_data", prog_data, 32'd0);
      checkOutput("rst_start", 32'(start), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_load_err", 32'(load_err), 32'd0);
      checkOutput("rst_skip_start", 32'(start2), 32'd1);
      rst = 1'b0;
      waitCycles(2);
      checkOutput("skip_start_run", 32'(start2), 32'd1);

      // Good two-word frame; checksum 13^93^10 = 90.
      applyStimulus(8'hA5);
      checkOutput("f1_busy_len0", 32'(busy), 32'd1);
      checkOutput("f1_start_low", 32'(start), 32'd0);
      applyStimulus(8'h02);
      applyStimulus(8'h00);
      applyStimulus(8'h13);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      checkOutput("f1_w0_en", 32'(prog_en), 32'd1);
      checkOutput("f1_w0_addr", prog_addr, 32'h0);
      checkOutput("f1_w0_data", prog_data, 32'h00000013);
      applyStimulus(8'h93);
      checkOutput("f1_en_pulse", 32'(prog_en), 32'd0);
      applyStimulus(8'h00);
      applyStimulus(8'h10);
      applyStimulus(8'h00);
      checkOutput("f1_w1_en", 32'(prog_en), 32'd1);
      checkOutput("f1_w1_addr", prog_addr, 32'h4);
      checkOutput("f1_w1_data", prog_data, 32'h00100093);
      checkOutput("f1_busy_csum", 32'(busy), 32'd1);
      applyStimulus(8'h90);
      checkOutput("f1_start", 32'(start), 32'd1);
      checkOutput("f1_busy_done", 32'(busy), 32'd0);
      checkOutput("f1_load_err", 32'(load_err), 32'd0);
      checkOutput("f1_en_after", 32'(prog_en), 32'd0);
      waitCycles(1);
      checkOutput("f1_wr_count", 32'(wr_addr.size()), 32'd2);

      // Same frame, wrong checksum.
      applyStimulus(8'hA5);
      checkOutput("bad_start_drop", 32'(start), 32'd0);
      applyStimulus(8'h02);
      applyStimulus(8'h00);
      applyStimulus(8'h13); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
      applyStimulus(8'h93); applyStimulus(8'h00); applyStimulus(8'h10); applyStimulus(8'h00);
      applyStimulus(8'h91);
      checkOutput("bad_load_err", 32'(load_err), 32'd1);
      checkOutput("bad_start", 32'(start), 32'd0);
      checkOutput("bad_busy", 32'(busy), 32'd0);
      waitCycles(3);
      checkOutput("bad_err_sticky", 32'(load_err), 32'd1);
      checkOutput("bad_wr_count", 32'(wr_addr.size()), 32'd4);

      // A fresh good frame recovers from the error.
      applyStimulus(8'hA5);
      checkOutput("rec_err_clear", 32'(load_err), 32'd0);
      applyStimulus(8'h02);
      applyStimulus(8'h00);
      applyStimulus(8'h13); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
      applyStimulus(8'h93); applyStimulus(8'h00); applyStimulus(8'h10); applyStimulus(8'h00);
      applyStimulus(8'h90);
      checkOutput("rec_start", 32'(start), 32'd1);
      checkOutput("rec_load_err", 32'(load_err), 32'd0);

      // Reload while running with an empty image.
      waitCycles(1);
      base = wr_addr.size();
      applyStimulus(8'h37);
      checkOutput("run_ignore_byte", 32'(start), 32'd1);
      applyStimulus(8'hA5);
      checkOutput("reload_start_drop", 32'(start), 32'd0);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      checkOutput("reload_csum_busy", 32'(busy), 32'd1);
      applyStimulus(8'h00);
      checkOutput("reload_start", 32'(start), 32'd1);
      waitCycles(1);
      checkOutput("reload_no_write", 32'(wr_addr.size()), 32'(base));

      // Oversize count 1025 is rejected right after LEN1.
      applyStimulus(8'hA5);
      applyStimulus(8'h01);
      applyStimulus(8'h04);
      checkOutput("big_load_err", 32'(load_err), 32'd1);
      checkOutput("big_busy", 32'(busy), 32'd0);
      checkOutput("big_start", 32'(start), 32'd0);
      waitCycles(2);
      checkOutput("big_no_write", 32'(wr_addr.size()), 32'(base));

      // MAGIC bytes inside the payload are plain data.
      applyStimulus(8'hA5);
      applyStimulus(8'h01);
      applyStimulus(8'h00);
      applyStimulus(8'hA5);
      checkOutput("mag_busy", 32'(busy), 32'd1);
      applyStimulus(8'hA5);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      checkOutput("mag_en", 32'(prog_en), 32'd1);
      checkOutput("mag_addr", prog_addr, 32'h0);
      checkOutput("mag_data", prog_data, 32'h0000A5A5);
      applyStimulus(8'h00);
      checkOutput("mag_start", 32'(start), 32'd1);

      // Timeout: a byte on the expiry cycle is accepted, a full stall errors.
      applyStimulus(8'hA5);
      applyStimulus(8'h01);
      applyStimulus(8'h00);
      applyStimulus(8'h11);
      waitCycles(TMO - 1);
      applyStimulus(8'h22);
      checkOutput("tmo_edge_busy", 32'(busy), 32'd1);
      checkOutput("tmo_edge_err", 32'(load_err), 32'd0);
      waitCycles(TMO - 1);
      checkOutput("tmo_pre_busy", 32'(busy), 32'd1);
      waitCycles(1);
      checkOutput("tmo_busy", 32'(busy), 32'd0);
      checkOutput("tmo_load_err", 32'(load_err), 32'd1);
      checkOutput("tmo_start", 32'(start), 32'd0);

      // Reset on the cycle that would otherwise write the second word.
      applyStimulus(8'hA5);
      applyStimulus(8'h02);
      applyStimulus(8'h00);
      applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h03); applyStimulus(8'h04);
      applyStimulus(8'h05); applyStimulus(8'h06); applyStimulus(8'h07);
      base = wr_addr.size();
      rst      = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h08;
      @(negedge clk);
      rx_valid = 1'b0;
      checkOutput("mid_rst_prog_en", 32'(prog_en), 32'd0);
      checkOutput("mid_rst_addr", prog_addr, 32'd0);
      checkOutput("mid_rst_data", prog_data, 32'd0);
      checkOutput("mid_rst_start", 32'(start), 32'd0);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_load_err", 32'(load_err), 32'd0);
      checkOutput("mid_rst_skip_start", 32'(start2), 32'd1);
      rst = 1'b0;
      waitCycles(2);
      checkOutput("mid_rst_no_write", 32'(wr_addr.size()), 32'(base));
      checkOutput("mid_rst_idle_busy", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
